// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner register for four active-low bus masters; optional BUS_ARB_TIMEOUT_EN.
// Latency: one clock from a sampled request to the grant; reset parks master 0 asynchronously.
// Backpressure: none; the owner keeps the bus while requesting (bounded by TIMEOUT_CYCLES with the timeout).
`timescale 1ns/1ps
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] m_req_,
  output logic [3:0] m_grnt_,
  output logic [1:0] owner
);

  logic [1:0] owner_q;
  logic [1:0] owner_d;
  logic [3:0] req;        // active-high copy of the request lines
  logic [3:0] others;     // requests excluding the current owner
  logic       other_req;
  logic       owner_req;
  logic       force_rel;  // timeout forces a rotation although the owner still requests
  logic [1:0] cand;
  logic       found;

  assign req = ~m_req_;

  // Split the sampled requests into "owner" and "everyone else".
  always_comb begin
    others          = req;
    others[owner_q] = 1'b0;
    other_req       = |others;
    owner_req       = req[owner_q];
  end

  // Next owner: hold while the owner requests, otherwise scan owner+1..owner+3; park if nobody else wants it.
  always_comb begin
    owner_d = owner_q;
    cand    = owner_q;
    found   = 1'b0;
    if (!owner_req || force_rel) begin
      for (int k = 1; k < 4; k++) begin
        cand = owner_q + 2'(k);
        if (!found && req[cand]) begin
          owner_d = cand;
          found   = 1'b1;
        end
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] hold_cnt_q;
  logic [CW-1:0] hold_cnt_d;

  assign force_rel = other_req && (hold_cnt_q == CNT_MAX);

  // Count contended holding cycles; any owner change or an uncontended cycle restarts the count.
  always_comb begin
    hold_cnt_d = '0;
    if (owner_req && other_req && !force_rel) begin
      hold_cnt_d = hold_cnt_q + CW'(1);
    end
  end

  // Hold counter register, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign force_rel = 1'b0;
`endif

  // Ownership register; reset parks master 0 without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= 2'd0;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Grant is a pure decode of the owner register, so it never glitches on request changes.
  always_comb begin
    m_grnt_          = 4'b1111;
    m_grnt_[owner_q] = 1'b0;
  end

  assign owner = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scenario tasks for bus_arbiter with a queue of expected grant/owner pairs.
// Latency: expectations are compared one cycle after the request pattern is applied.
// Backpressure: not applicable; a watchdog bounds the whole run.
`timescale 1ns/1ps
module tb_bus_arbiter;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] m_req_;
  logic [3:0] m_grnt_;
  logic [1:0] owner;

  int tests_run    = 0;
  int tests_failed = 0;

  // expected {m_grnt_, owner}, pushed when stimulus is driven
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .reset   (reset),
    .m_req_  (m_req_),
    .m_grnt_ (m_grnt_),
    .owner   (owner)
  );

  function automatic logic [3:0] gnt_of(input int o);
    logic [3:0] g;
    g = 4'b1111;
    g[o] = 1'b0;
    return g;
  endfunction

  task automatic test_reset;
    logic [5:0] e;
    reset  = 1'b1;
    m_req_ = 4'b1111;
    #12;
    tests_run++;
    if (m_grnt_ !== 4'b1110 || owner !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_initial: grnt=%b owner=%0d, expected grnt=1110 owner=0", m_grnt_, owner);
    end
    @(negedge clk);
    reset  = 1'b0;
    m_req_ = 4'b1101;
    exp_q.push_back({4'b1101, 2'd1});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    tests_run++;
    if (m_grnt_ !== e[5:2] || owner !== e[1:0]) begin
      tests_failed++;
      $display("FAIL reset_preload: grnt=%b owner=%0d, expected grnt=%b owner=%0d", m_grnt_, owner, e[5:2], e[1:0]);
    end
    // all masters requesting, then reset asserted between edges
    m_req_ = 4'b0000;
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (m_grnt_ !== 4'b1110 || owner !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_async: grnt=%b owner=%0d, expected grnt=1110 owner=0", m_grnt_, owner);
    end
    #1;
    reset  = 1'b0;
    m_req_ = 4'b1111;
    exp_q.push_back({4'b1110, 2'd0});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    tests_run++;
    if (m_grnt_ !== e[5:2] || owner !== e[1:0]) begin
      tests_failed++;
      $display("FAIL reset_parked: grnt=%b owner=%0d, expected grnt=%b owner=%0d", m_grnt_, owner, e[5:2], e[1:0]);
    end
  endtask

  task automatic test_single_handover;
    logic [3:0] reqs [0:2];
    logic [5:0] exps [0:2];
    logic [5:0] e;
    reqs = '{4'b1101, 4'b1111, 4'b1111};
    exps = '{{4'b1101, 2'd1}, {4'b1101, 2'd1}, {4'b1101, 2'd1}};
    for (int i = 0; i < 3; i++) begin
      m_req_ = reqs[i];
      exp_q.push_back(exps[i]);
      if (i == 0) begin
        #1;
        tests_run++;
        if (m_grnt_ !== 4'b1110) begin
          tests_failed++;
          $display("FAIL handover_no_comb_path: grnt=%b before edge, expected 1110", m_grnt_);
        end
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      tests_run++;
      if (m_grnt_ !== e[5:2] || owner !== e[1:0]) begin
        tests_failed++;
        $display("FAIL handover step %0d: grnt=%b owner=%0d, expected grnt=%b owner=%0d", i, m_grnt_, owner, e[5:2], e[1:0]);
      end
    end
  endtask

  task automatic test_round_robin_wrap;
    logic [3:0] reqs [0:3];
    logic [5:0] exps [0:3];
    logic [5:0] e;
    reqs = '{4'b1011, 4'b0010, 4'b0110, 4'b1110};
    exps = '{{4'b1011, 2'd2}, {4'b1011, 2'd2}, {4'b0111, 2'd3}, {4'b1110, 2'd0}};
    for (int i = 0; i < 4; i++) begin
      m_req_ = reqs[i];
      exp_q.push_back(exps[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      tests_run++;
      if (m_grnt_ !== e[5:2] || owner !== e[1:0]) begin
        tests_failed++;
        $display("FAIL rr_wrap step %0d: grnt=%b owner=%0d, expected grnt=%b owner=%0d", i, m_grnt_, owner, e[5:2], e[1:0]);
      end
    end
  endtask

  task automatic test_starvation;
    logic [5:0] e;
    int nxt;
    for (int o = 0; o < 4; o++) begin
      for (int c = 0; c < 4; c++) begin
        nxt = (c == 3) ? (o + 1) % 4 : o;
        m_req_ = (c == 3) ? 4'(1 << o) : 4'b0000;
        exp_q.push_back({gnt_of(nxt), 2'(nxt)});
        @(posedge clk); #1;
        e = exp_q.pop_front();
        tests_run++;
        if (m_grnt_ !== e[5:2] || owner !== e[1:0]) begin
          tests_failed++;
          $display("FAIL starvation owner %0d cycle %0d: grnt=%b owner=%0d, expected grnt=%b owner=%0d", o, c, m_grnt_, owner, e[5:2], e[1:0]);
        end
      end
    end
  endtask

  task automatic test_timeout;
    logic [5:0] e;
    int o;
    m_req_ = 4'b1101;
    exp_q.push_back({4'b1101, 2'd1});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    tests_run++;
    if (m_grnt_ !== e[5:2] || owner !== e[1:0]) begin
      tests_failed++;
      $display("FAIL timeout_setup: grnt=%b owner=%0d, expected grnt=%b owner=%0d", m_grnt_, owner, e[5:2], e[1:0]);
    end
    // masters 1 and 3 both hold their requests
    o = 1;
    for (int n = 1; n <= 100; n++) begin
      m_req_ = 4'b0101;
`ifdef BUS_ARB_TIMEOUT_EN
      o = ((n / TO) % 2 == 0) ? 1 : 3;
`endif
      exp_q.push_back({gnt_of(o), 2'(o)});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      tests_run++;
      if (m_grnt_ !== e[5:2] || owner !== e[1:0]) begin
        tests_failed++;
        $display("FAIL timeout contention cycle %0d: grnt=%b owner=%0d, expected grnt=%b owner=%0d", n, m_grnt_, owner, e[5:2], e[1:0]);
      end
    end
    m_req_ = 4'b1111;
    exp_q.push_back({gnt_of(o), 2'(o)});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    tests_run++;
    if (m_grnt_ !== e[5:2] || owner !== e[1:0]) begin
      tests_failed++;
      $display("FAIL timeout_park: grnt=%b owner=%0d, expected grnt=%b owner=%0d", m_grnt_, owner, e[5:2], e[1:0]);
    end
  endtask

  task automatic test_reset_mid_op;
    logic [3:0] reqs [0:2];
    logic [5:0] e;
    reqs = '{4'b0111, 4'b0110, 4'b0110};
    // owner 3, then two contended cycles to advance the hold counter
    for (int i = 0; i < 3; i++) begin
      m_req_ = reqs[i];
      exp_q.push_back({4'b0111, 2'd3});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      tests_run++;
      if (m_grnt_ !== e[5:2] || owner !== e[1:0]) begin
        tests_failed++;
        $display("FAIL midreset_setup step %0d: grnt=%b owner=%0d, expected grnt=%b owner=%0d", i, m_grnt_, owner, e[5:2], e[1:0]);
      end
    end
    #3;
    reset = 1'b1;
    #1;
    tests_run++;
    if (m_grnt_ !== 4'b1110 || owner !== 2'd0) begin
      tests_failed++;
      $display("FAIL midreset_async: grnt=%b owner=%0d, expected grnt=1110 owner=0", m_grnt_, owner);
    end
    @(negedge clk);
    reset = 1'b0;
    // owner 0 holds against master 3; a stale counter would preempt early
    for (int i = 0; i < 3; i++) begin
      m_req_ = 4'b0110;
      exp_q.push_back({4'b1110, 2'd0});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      tests_run++;
      if (m_grnt_ !== e[5:2] || owner !== e[1:0]) begin
        tests_failed++;
        $display("FAIL midreset_counter_cleared cycle %0d: grnt=%b owner=%0d, expected grnt=%b owner=%0d", i, m_grnt_, owner, e[5:2], e[1:0]);
      end
    end
    m_req_ = 4'b0111;
    exp_q.push_back({4'b0111, 2'd3});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    tests_run++;
    if (m_grnt_ !== e[5:2] || owner !== e[1:0]) begin
      tests_failed++;
      $display("FAIL midreset_resume: grnt=%b owner=%0d, expected grnt=%b owner=%0d", m_grnt_, owner, e[5:2], e[1:0]);
    end
  endtask

  task automatic test_random;
    logic [5:0] e;
    logic [3:0] r;
    int m_o;
    int m_c;
    int nxt;
    bit other;
    bit forced;
    m_o = 3;
    m_c = 0;
    for (int n = 0; n < 300; n++) begin
      r = 4'($urandom_range(0, 15));
      m_req_ = r;
      other = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (j != m_o && r[j] == 1'b0) other = 1'b1;
      end
      forced = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      forced = other && (m_c == TO - 1);
`endif
      nxt = m_o;
      if (r[m_o] == 1'b0 && !forced) begin
        m_c = other ? m_c + 1 : 0;
      end else begin
        for (int k = 3; k >= 1; k--) begin
          if (r[(m_o + k) % 4] == 1'b0) nxt = (m_o + k) % 4;
        end
        m_c = 0;
      end
      m_o = nxt;
      exp_q.push_back({gnt_of(nxt), 2'(nxt)});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      tests_run++;
      if (m_grnt_ !== e[5:2] || owner !== e[1:0]) begin
        tests_failed++;
        $display("FAIL random cycle %0d req=%b: grnt=%b owner=%0d, expected grnt=%b owner=%0d", n, r, m_grnt_, owner, e[5:2], e[1:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_handover();
    test_round_robin_wrap();
    test_starvation();
    test_timeout();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded 100000 ns, expected completion well before");
    $fatal(1, "watchdog expired");
  end

endmodule
